// File: rtl/counter_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sched_pkg
//  Purpose  : Shared types and constants for the counter scheduler.
//  Revision : 1.0  initial release
// ============================================================================
package counter_sched_pkg;

    localparam int c_STEP_W = 3;
    localparam logic [c_STEP_W-1:0] c_STEP_ONE = {{(c_STEP_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef logic [1:0] req_oh_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin selector; pref picks the winner on a tie.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
    import counter_sched_pkg::*;
(
    input  req_oh_t req,
    input  logic    pref,
    output req_oh_t grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = pref ? 2'b10 : 2'b01;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_sched.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sched
//  Purpose  : Shares one up/down binary/gray counter between two requesters.
//             Define COUNTER_SCHED_CLEAR_EN to clear the counter before each job.
//  Revision : 1.0  initial release
// ============================================================================
module counter_sched
    import counter_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  req_oh_t             req,
    input  logic                dir0,
    input  logic                dir1,
    input  logic                mode0,
    input  logic                mode1,
    input  logic [c_STEP_W-1:0] steps0,
    input  logic [c_STEP_W-1:0] steps1,
    output req_oh_t             gnt,
    output req_oh_t             done,
    output logic                cnt_cen,
    output logic                cnt_updn,
    output logic                cnt_m,
    output logic                cnt_rst,
    output logic                busy
);

    state_e              r_state;
    logic                r_pref;
    logic [c_STEP_W-1:0] r_steps;
    logic [c_STEP_W-1:0] r_step;
    req_oh_t             w_win;
    logic                w_dir;
    logic                w_mode;
    logic [c_STEP_W-1:0] w_steps;

    rr_arb2 u_arb (
        .req   (req),
        .pref  (r_pref),
        .grant (w_win)
    );

    assign w_dir   = w_win[1] ? dir1   : dir0;
    assign w_mode  = w_win[1] ? mode1  : mode0;
    assign w_steps = w_win[1] ? steps1 : steps0;

`ifdef COUNTER_SCHED_CLEAR_EN
    logic r_clr;
    assign cnt_rst = rst | r_clr;
`else
    assign cnt_rst = rst;
`endif

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            gnt      <= 2'b00;
            done     <= 2'b00;
            cnt_cen  <= 1'b0;
            cnt_updn <= 1'b1;
            cnt_m    <= 1'b0;
            r_pref   <= 1'b0;
            r_steps  <= '0;
            r_step   <= '0;
`ifdef COUNTER_SCHED_CLEAR_EN
            r_clr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt      <= w_win;
                        cnt_updn <= w_dir;
                        cnt_m    <= w_mode;
                        r_steps  <= w_steps;
                        r_step   <= '0;
`ifdef COUNTER_SCHED_CLEAR_EN
                        r_clr    <= 1'b1;
                        r_state  <= CLR;
`else
                        cnt_cen  <= 1'b1;
                        r_state  <= RUN;
`endif
                    end
                end
`ifdef COUNTER_SCHED_CLEAR_EN
                CLR: begin
                    r_clr   <= 1'b0;
                    cnt_cen <= 1'b1;
                    r_state <= RUN;
                end
`endif
                RUN: begin
                    // r_step counts enabled cycles already issued, so the
                    // last one is the cycle where it equals the latched length.
                    if (r_step == r_steps) begin
                        cnt_cen <= 1'b0;
                        done    <= gnt;
                        r_state <= DONE;
                    end else begin
                        r_step  <= r_step + c_STEP_ONE;
                    end
                end
                DONE: begin
                    done    <= 2'b00;
                    gnt     <= 2'b00;
                    r_pref  <= gnt[0];
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
